// File: rtl/if_stage.sv
// Instruction fetch: holds the PC and fetches over a variable-latency req/valid port (one outstanding).
// IF/ID is registered; stall parks a returned word in hold_buf, redirect squashes and drains the stale fetch.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCWrite,
    input  logic        freeze,
    input  logic        PCSrc,
    input  logic [31:0] Branch_Address,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic [31:0] Instruction,
    output logic [31:0] Next_Address,
    output logic        if_valid,
    output logic [31:0] pc
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] hold_buf;
    logic [31:0] drain_addr;
    logic [31:0] pc_plus4;
    logic        stall;

    assign stall     = ~PCWrite | freeze;
    assign pc_plus4  = pc + 32'd4;
    assign imem_req  = ~rst && (state != HOLD);
    // In DRAIN the PC already points at the redirect target; the bus must keep the stale address.
    assign imem_addr = (state == DRAIN) ? drain_addr : pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc           <= RESET_PC;
            Instruction  <= NOP_INSTR;
            Next_Address <= 32'd0;
            if_valid     <= 1'b0;
            hold_buf     <= 32'd0;
            drain_addr   <= 32'd0;
            state        <= FETCH;
        end else if (PCSrc) begin
            pc           <= Branch_Address;
            Instruction  <= NOP_INSTR;
            Next_Address <= 32'd0;
            if_valid     <= 1'b0;
            hold_buf     <= 32'd0;
            if (state == FETCH && !imem_valid) begin
                drain_addr <= pc;
                state      <= DRAIN;
            end else if (state == DRAIN && !imem_valid) begin
                state <= DRAIN;
            end else begin
                state <= FETCH;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (imem_valid) begin
                        if (!stall) begin
                            Instruction  <= imem_rdata;
                            Next_Address <= pc_plus4;
                            if_valid     <= 1'b1;
                            pc           <= pc_plus4;
                        end else begin
                            hold_buf <= imem_rdata;
                            state    <= HOLD;
                        end
                    end else if (!stall) begin
                        Instruction <= NOP_INSTR;
                        if_valid    <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        Instruction  <= hold_buf;
                        Next_Address <= pc_plus4;
                        if_valid     <= 1'b1;
                        pc           <= pc_plus4;
                        state        <= FETCH;
                    end
                end
                DRAIN: begin
                    if (imem_valid) begin
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage: bench-side variable-latency memory plus a flag-based reference model.
module tb_if_stage;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFFC;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam int          NCYC   = 3000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        PCWrite = 1'b1;
    logic        freeze = 1'b0;
    logic        PCSrc = 1'b0;
    logic [31:0] Branch_Address = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'd0;
    logic        imem_valid = 1'b0;
    logic [31:0] Instruction;
    logic [31:0] Next_Address;
    logic        if_valid;
    logic [31:0] pc;

    int checks = 0;
    int errors = 0;

    if_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst), .PCWrite(PCWrite), .freeze(freeze), .PCSrc(PCSrc),
        .Branch_Address(Branch_Address), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_valid(imem_valid), .Instruction(Instruction),
        .Next_Address(Next_Address), .if_valid(if_valid), .pc(pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Reference model: which words exist, not how the FSM encodes it.
    logic [31:0] m_pc, m_instr, m_na, m_held_word, m_stale_addr;
    logic        m_v, m_held, m_stale;

    task automatic model_reset();
        m_pc = RST_PC; m_instr = NOP; m_na = 32'd0; m_v = 1'b0;
        m_held = 1'b0; m_held_word = 32'd0; m_stale = 1'b0; m_stale_addr = 32'd0;
    endtask

    task automatic deliver(input logic [31:0] w);
        m_instr = w; m_na = m_pc + 32'd4; m_v = 1'b1; m_pc = m_pc + 32'd4;
    endtask

    task automatic model_step(input bit r, input bit stall, input bit redir,
                              input logic [31:0] tgt, input bit vld, input logic [31:0] w);
        if (r) begin
            model_reset();
        end else if (redir) begin
            if (!m_held && !vld) begin
                if (!m_stale) m_stale_addr = m_pc;
                m_stale = 1'b1;
            end else begin
                m_stale = 1'b0;
            end
            m_held = 1'b0;
            m_instr = NOP; m_na = 32'd0; m_v = 1'b0; m_pc = tgt;
        end else if (m_stale) begin
            if (vld) m_stale = 1'b0;
        end else if (m_held) begin
            if (!stall) begin
                deliver(m_held_word);
                m_held = 1'b0;
            end
        end else if (vld && !stall) begin
            deliver(w);
        end else if (vld) begin
            m_held = 1'b1; m_held_word = w;
        end else if (!stall) begin
            m_instr = NOP; m_v = 1'b0;
        end
    endtask

    bit          mem_busy = 1'b0;
    int          mem_lat = 0;
    logic [31:0] mem_addr = 32'd0;

    initial begin
        model_reset();
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            int  lat;
            bit  stall_now;
            bit  vld;
            @(posedge clk);
            #1;
            if (cyc < 2) begin
                rst = 1'b1; PCWrite = 1'b1; freeze = 1'b0; PCSrc = 1'b0; lat = 0;
            end else if (cyc < 40) begin
                rst = 1'b0; PCWrite = 1'b1; freeze = 1'b0; PCSrc = 1'b0; lat = 0;
            end else if (cyc < 100) begin
                rst = 1'b0; PCWrite = 1'b1; freeze = 1'b0; PCSrc = 1'b0; lat = 1;
            end else begin
                rst     = ($urandom_range(0, 99) == 0);
                PCWrite = ($urandom_range(0, 99) >= 20);
                freeze  = ($urandom_range(0, 99) < 15);
                PCSrc   = ($urandom_range(0, 99) < 8);
                lat     = $urandom_range(0, 3);
            end
            case ($urandom_range(0, 3))
                0:       Branch_Address = 32'hFFFF_FFF8;
                1:       Branch_Address = {$urandom_range(0, 255), 2'b00};
                default: Branch_Address = $urandom;
            endcase
            #1;
            vld = 1'b0;
            if (rst) begin
                mem_busy = 1'b0;
            end else begin
                if (imem_req && !mem_busy) begin
                    mem_busy = 1'b1; mem_lat = lat; mem_addr = imem_addr;
                end else if (mem_busy) begin
                    check("addr_stable", imem_addr, mem_addr);
                end
                if (mem_busy) begin
                    if (mem_lat == 0) begin
                        vld = 1'b1; mem_busy = 1'b0;
                    end else begin
                        mem_lat--;
                    end
                end
            end
            imem_valid = vld;
            imem_rdata = vld ? mem_word(mem_addr) : $urandom;
            #1;
            check("pc", pc, m_pc);
            check("instruction", Instruction, m_instr);
            check("next_address", Next_Address, m_na);
            check("if_valid", {31'd0, if_valid}, {31'd0, m_v});
            check("imem_req", {31'd0, imem_req}, {31'd0, !rst && !m_held});
            if (!rst && !m_held)
                check("imem_addr", imem_addr, m_stale ? m_stale_addr : m_pc);
            stall_now = !PCWrite || freeze;
            model_step(rst, stall_now, PCSrc, Branch_Address, vld, imem_rdata);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
